// File: rtl/eflash_col_readout.sv
// eflash_col_readout: samples the 128 column sense-amp outputs at the
// mode-specific exec_cnt phase of a PIM operation. The captured bits are
// streamed out as 32-bit words over a valid/ready handshake.
//
// Optional feature macro: EFLASH_READOUT_POPCNT_EN
//   defined   -> popcnt_o holds the number of ones in the last capture
//   undefined -> popcnt_o is tied to zero and no counter is built
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | no capture held; waiting for a sample event
// DRAIN | capture held; presenting beats until the last one transfers

module eflash_col_readout #(
    parameter logic [3:0] SAMPLE_CNT_READ = 4'd3,
    parameter logic [3:0] SAMPLE_CNT_PAR  = 4'd6,
    parameter logic [3:0] SAMPLE_CNT_RBR  = 4'd3
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic         pim_en_i,
    input  logic [2:0]   pim_mode_i,
    input  logic [3:0]   exec_cnt_i,
    input  logic [8:0]   col_addr9_i,
    input  logic [127:0] SAOUT_i,
    input  logic         clr_ovr_i,
    output logic [31:0]  rdata_o,
    output logic         rvalid_o,
    output logic         rlast_o,
    input  logic         rready_i,
    output logic         busy_o,
    output logic         overrun_o,
    output logic [7:0]   popcnt_o
);

    localparam logic [2:0] MODE_READ = 3'b011;
    localparam logic [2:0] MODE_PAR  = 3'b101;
    localparam logic [2:0] MODE_RBR  = 3'b110;

    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_DRAIN = 1'b1;

    logic [0:0]   state_q;
    logic [3:0]   exec_cnt_q;
    logic [127:0] cap_q;
    logic [1:0]   idx_q;
    // beats still to transfer, including the one currently presented
    logic [2:0]   beats_left_q;

    logic         mode_ok;
    logic [3:0]   sample_cnt;
    logic         sample_ev;
    logic         is_read;
    logic [1:0]   start_idx;
    logic [1:0]   next_idx;
    logic         xfer;
    logic         cap_load;

    // only the word-select bits of the column address matter here
    logic         unused_col_bits;
    assign unused_col_bits = ^col_addr9_i[6:0];

    // Decode the capturing modes and their sample phase
    always_comb begin
        mode_ok    = 1'b0;
        sample_cnt = 4'hF;
        case (pim_mode_i)
            MODE_READ: begin
                mode_ok    = 1'b1;
                sample_cnt = SAMPLE_CNT_READ;
            end
            MODE_PAR: begin
                mode_ok    = 1'b1;
                sample_cnt = SAMPLE_CNT_PAR;
            end
            MODE_RBR: begin
                mode_ok    = 1'b1;
                sample_cnt = SAMPLE_CNT_RBR;
            end
            default: begin
                mode_ok    = 1'b0;
                sample_cnt = 4'hF;
            end
        endcase
    end

    // Edge-qualified so a counter stalled at the sample value fires once
    assign sample_ev = pim_en_i && mode_ok && (exec_cnt_i == sample_cnt) &&
                       (exec_cnt_q != exec_cnt_i);

    assign is_read   = (pim_mode_i == MODE_READ);
    assign start_idx = is_read ? col_addr9_i[8:7] : 2'd0;
    assign next_idx  = idx_q + 2'd1;
    assign xfer      = rvalid_o && rready_i;
    assign cap_load  = (state_q == ST_IDLE) && sample_ev;

    // Remember the previous controller phase for event edge detection
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            exec_cnt_q <= 4'hF;
        end else begin
            exec_cnt_q <= exec_cnt_i;
        end
    end

    // Capture and drain sequencing
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q      <= ST_IDLE;
            cap_q        <= '0;
            idx_q        <= 2'd0;
            beats_left_q <= 3'd0;
            rdata_o      <= 32'd0;
            rvalid_o     <= 1'b0;
            rlast_o      <= 1'b0;
            busy_o       <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (sample_ev) begin
                        cap_q        <= SAOUT_i;
                        idx_q        <= start_idx;
                        beats_left_q <= is_read ? 3'd1 : 3'd4;
                        rdata_o      <= SAOUT_i[{start_idx, 5'd0} +: 32];
                        rlast_o      <= is_read;
                        rvalid_o     <= 1'b1;
                        busy_o       <= 1'b1;
                        state_q      <= ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    if (xfer) begin
                        if (beats_left_q == 3'd1) begin
                            rvalid_o     <= 1'b0;
                            busy_o       <= 1'b0;
                            rlast_o      <= 1'b0;
                            beats_left_q <= 3'd0;
                            state_q      <= ST_IDLE;
                        end else begin
                            idx_q        <= next_idx;
                            beats_left_q <= beats_left_q - 3'd1;
                            rdata_o      <= cap_q[{next_idx, 5'd0} +: 32];
                            rlast_o      <= (beats_left_q == 3'd2);
                        end
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    // Sticky overrun: a sample event while a capture is still held
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            overrun_o <= 1'b0;
        end else if (sample_ev && (state_q == ST_DRAIN)) begin
            overrun_o <= 1'b1;
        end else if (clr_ovr_i) begin
            overrun_o <= 1'b0;
        end
    end

`ifdef EFLASH_READOUT_POPCNT_EN
    logic [7:0] pop_next;

    // Ones count over all 128 sense-amp bits, loaded with the capture
    always_comb begin
        pop_next = 8'd0;
        for (int i = 0; i < 128; i++) begin
            pop_next = pop_next + {7'd0, SAOUT_i[i]};
        end
    end

    // Hold the count alongside the capture until the next one
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            popcnt_o <= 8'd0;
        end else if (cap_load) begin
            popcnt_o <= pop_next;
        end
    end
`else
    logic unused_cap_load;
    assign unused_cap_load = cap_load;
    assign popcnt_o        = 8'd0;
`endif

endmodule

// File: tb/tb_eflash_col_readout.sv
// Testbench for eflash_col_readout: directed scenarios plus randomized
// operations, checked against a queue-based model of expected beats.
module tb_eflash_col_readout;

    localparam logic [2:0] M_READ = 3'b011;
    localparam logic [2:0] M_PAR  = 3'b101;
    localparam logic [2:0] M_RBR  = 3'b110;

    logic         clk_i = 1'b0;
    logic         rst_ni;
    logic         pim_en_i;
    logic [2:0]   pim_mode_i;
    logic [3:0]   exec_cnt_i;
    logic [8:0]   col_addr9_i;
    logic [127:0] SAOUT_i;
    logic         clr_ovr_i;
    logic [31:0]  rdata_o;
    logic         rvalid_o;
    logic         rlast_o;
    logic         rready_i;
    logic         busy_o;
    logic         overrun_o;
    logic [7:0]   popcnt_o;

    eflash_col_readout dut (
        .clk_i      (clk_i),
        .rst_ni     (rst_ni),
        .pim_en_i   (pim_en_i),
        .pim_mode_i (pim_mode_i),
        .exec_cnt_i (exec_cnt_i),
        .col_addr9_i(col_addr9_i),
        .SAOUT_i    (SAOUT_i),
        .clr_ovr_i  (clr_ovr_i),
        .rdata_o    (rdata_o),
        .rvalid_o   (rvalid_o),
        .rlast_o    (rlast_o),
        .rready_i   (rready_i),
        .busy_o     (busy_o),
        .overrun_o  (overrun_o),
        .popcnt_o   (popcnt_o)
    );

    always #5 clk_i = ~clk_i;

    int n_assert = 0;
    int n_fail   = 0;

    // model state: words still owed by the current capture
    logic [31:0] q[$];
    logic        m_ovr  = 1'b0;
    logic [7:0]  m_pop  = 8'd0;
    logic [3:0]  m_prev = 4'hF;

    int rr_mode = 0;      // 0 ready high, 1 random, 2 low, 3 toggle
    bit rnd_clr = 1'b0;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic bit cap_mode(input logic [2:0] m);
        return (m == M_READ) || (m == M_PAR) || (m == M_RBR);
    endfunction

    function automatic logic [3:0] samp(input logic [2:0] m);
        return (m == M_PAR) ? 4'd6 : 4'd3;
    endfunction

    task automatic check_outputs();
        chk("rvalid", rvalid_o, q.size() > 0);
        chk("busy", busy_o, q.size() > 0);
        chk("overrun", overrun_o, m_ovr);
        chk("popcnt", popcnt_o, m_pop);
        if (q.size() > 0) begin
            chk("rdata", rdata_o, q[0]);
            chk("rlast", rlast_o, q.size() == 1);
        end
    endtask

    // one clock: model what the edge should do, then compare
    task automatic tick();
        logic         ev;
        logic         busy_b;
        logic         rr;
        logic         clr;
        logic [2:0]   md;
        logic [127:0] sa;
        logic [8:0]   col;
        case (rr_mode)
            0:       rready_i = 1'b1;
            1:       rready_i = 1'($urandom_range(0, 1));
            2:       rready_i = 1'b0;
            default: rready_i = ~rready_i;
        endcase
        if (rnd_clr) clr_ovr_i = ($urandom_range(0, 7) == 0);
        md     = pim_mode_i;
        sa     = SAOUT_i;
        col    = col_addr9_i;
        rr     = rready_i;
        clr    = clr_ovr_i;
        ev     = pim_en_i && cap_mode(md) && (exec_cnt_i == samp(md)) && (exec_cnt_i != m_prev);
        busy_b = (q.size() > 0);
        m_prev = exec_cnt_i;
        @(posedge clk_i);
        #1;
        if (busy_b && rr) void'(q.pop_front());
        if (ev && busy_b) m_ovr = 1'b1;
        else if (clr) m_ovr = 1'b0;
        if (ev && !busy_b) begin
            if (md == M_READ) q.push_back(sa[32*col[8:7] +: 32]);
            else for (int k = 0; k < 4; k++) q.push_back(sa[32*k +: 32]);
`ifdef EFLASH_READOUT_POPCNT_EN
            m_pop = 8'($countones(sa));
`endif
        end
        check_outputs();
    endtask

    task automatic count_down(input logic [2:0] md, input int from, input int to);
        pim_mode_i = md;
        for (int e = from; e >= to; e--) begin
            exec_cnt_i = 4'(e);
            tick();
        end
    endtask

    task automatic drain(input int budget);
        int b = 0;
        while (q.size() > 0 && b < budget) begin
            tick();
            b++;
        end
        chk("drain_timeout", q.size(), 0);
    endtask

    task automatic do_reset();
        rst_ni = 1'b0;
        #1;
        q.delete();
        m_ovr  = 1'b0;
        m_pop  = 8'd0;
        m_prev = 4'hF;
        chk("rst_rvalid", rvalid_o, 1'b0);
        chk("rst_busy", busy_o, 1'b0);
        chk("rst_rlast", rlast_o, 1'b0);
        chk("rst_rdata", rdata_o, 32'd0);
        chk("rst_overrun", overrun_o, 1'b0);
        chk("rst_popcnt", popcnt_o, 8'd0);
        #2;
        rst_ni = 1'b1;
    endtask

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    initial begin : stim
        logic [2:0] inval [5];
        inval = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b111};
        rst_ni      = 1'b0;
        pim_en_i    = 1'b0;
        pim_mode_i  = 3'b000;
        exec_cnt_i  = 4'hF;
        col_addr9_i = 9'd0;
        SAOUT_i     = '0;
        clr_ovr_i   = 1'b0;
        rready_i    = 1'b0;
        #2;
        do_reset();
        tick();

        // READ: column 105 -> word 3, bit 9
        pim_en_i    = 1'b1;
        col_addr9_i = 9'h1A4;
        SAOUT_i     = '0;
        SAOUT_i[105] = 1'b1;
        rr_mode     = 0;
        count_down(M_READ, 9, 3);
        chk("read_word", rdata_o, 32'h0000_0200);
        chk("read_last", rlast_o, 1'b1);
        count_down(M_READ, 2, 1);
        chk("read_busy_done", busy_o, 1'b0);

        // PARALLEL: four beats in word order
        SAOUT_i = 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210;
        count_down(M_PAR, 9, 6);
        chk("par_beat0", rdata_o, 32'h7654_3210);
        chk("par_beat0_last", rlast_o, 1'b0);
`ifdef EFLASH_READOUT_POPCNT_EN
        chk("par_popcnt", popcnt_o, 8'd64);
`endif
        count_down(M_PAR, 5, 5);
        chk("par_beat1", rdata_o, 32'hFEDC_BA98);
        count_down(M_PAR, 4, 4);
        chk("par_beat2", rdata_o, 32'h89AB_CDEF);
        count_down(M_PAR, 3, 3);
        chk("par_beat3", rdata_o, 32'h0123_4567);
        chk("par_beat3_last", rlast_o, 1'b1);
        count_down(M_PAR, 2, 1);

        // RBR with a long stall, then toggling ready
        SAOUT_i = {$urandom, $urandom, $urandom, $urandom};
        rr_mode = 2;
        count_down(M_RBR, 9, 1);
        exec_cnt_i = 4'd0;
        for (int i = 0; i < 3; i++) tick();
        rready_i = 1'b0;
        rr_mode  = 3;
        drain(40);

        // exec_cnt stalled at the READ sample value
        rr_mode     = 0;
        col_addr9_i = 9'($urandom);
        SAOUT_i     = {$urandom, $urandom, $urandom, $urandom};
        count_down(M_READ, 9, 4);
        for (int i = 0; i < 4; i++) count_down(M_READ, 3, 3);
        count_down(M_READ, 2, 1);
        chk("stall_no_overrun", overrun_o, 1'b0);
        drain(10);

        // second PARALLEL event while beat 2 is pending
        rr_mode = 2;
        SAOUT_i = {$urandom, $urandom, $urandom, $urandom};
        count_down(M_PAR, 9, 1);
        rr_mode = 0;
        tick();
        rr_mode = 2;
        SAOUT_i = {$urandom, $urandom, $urandom, $urandom};
        count_down(M_PAR, 9, 5);
        chk("ovr_set", overrun_o, 1'b1);
        rr_mode = 0;
        count_down(M_PAR, 4, 1);
        drain(10);
        clr_ovr_i = 1'b1;
        tick();
        clr_ovr_i = 1'b0;
        chk("ovr_cleared", overrun_o, 1'b0);

        // non-capturing modes
        for (int i = 0; i < 5; i++) begin
            SAOUT_i = {$urandom, $urandom, $urandom, $urandom};
            count_down(inval[i], 9, 1);
            chk("inval_no_capture", rvalid_o, 1'b0);
        end

        // reset mid-drain after beat 1
        SAOUT_i = {$urandom, $urandom, $urandom, $urandom};
        count_down(M_PAR, 9, 5);
        do_reset();
        count_down(M_PAR, 4, 1);

        // randomized operations, some overlapping an unfinished drain
        rnd_clr = 1'b1;
        for (int it = 0; it < 40; it++) begin
            SAOUT_i     = {$urandom, $urandom, $urandom, $urandom};
            col_addr9_i = 9'($urandom);
            pim_en_i    = ($urandom_range(0, 9) != 0);
            rr_mode     = $urandom_range(0, 1);
            count_down(3'($urandom_range(0, 7)), 9, 1);
            if ($urandom_range(0, 2) != 0) drain(200);
        end
        rnd_clr   = 1'b0;
        clr_ovr_i = 1'b0;
        rr_mode   = 0;
        pim_en_i  = 1'b0;
        drain(20);
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/eflash_col_readout.md
Name: eflash_col_readout

Overview:
- Sense-side counterpart of the eFlash column driver. While the driver sequences DUMH/PRECB/DISC into the array, this block samples the 128 column sense-amp outputs at the correct exec_cnt phase of each PIM operation.
- It then streams the captured bits to the peripheral datapath as 32-bit words over a valid/ready handshake.
- It sits beside the column driver and is fed by the same pim_en / pim_mode / exec_cnt controller signals.

Parameters:
- SAMPLE_CNT_READ, 3, exec_cnt value at which SA outputs are sampled in PIM_READ (first cycle with DISC low).
- SAMPLE_CNT_PAR, 6, exec_cnt value at which SA outputs are sampled in PIM_PARALLEL.
- SAMPLE_CNT_RBR, 3, exec_cnt value at which SA outputs are sampled in PIM_RBR.

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  asynchronous active-low reset
- pim_en_i  in  1  PIM operation enable
- pim_mode_i  in  3  mode: 011 READ, 101 PARALLEL, 110 RBR; all other codes produce no capture
- exec_cnt_i  in  4  controller phase counter (counts down)
- col_addr9_i  in  9  column address; [8:2] selects SA column in READ
- SAOUT_i  in  128  sense-amp outputs, one per column
- clr_ovr_i  in  1  clears overrun_o
- rdata_o  out  32  output word
- rvalid_o  out  1  rdata_o valid
- rlast_o  out  1  final beat of the current capture
- rready_i  in  1  downstream accepts the beat
- busy_o  out  1  capture held and not yet fully drained
- overrun_o  out  1  sticky: a sample event was dropped
- popcnt_o  out  8  number of ones in the capture (optional feature)

Behaviour:
- Clock and reset: single clock; reset is asynchronous and active-low.
- Reset values: rdata_o=0, rvalid_o=0, rlast_o=0, busy_o=0, overrun_o=0, popcnt_o=0, capture register=0, exec_cnt_q=4'hF.
- Registered outputs: all outputs come directly from flops.
- exec_cnt_q: register holding the previous exec_cnt_i.
- Sample event (combinational in cycle N): pim_en_i=1, AND mode is READ/PARALLEL/RBR, AND exec_cnt_i == SAMPLE_CNT for that mode, AND exec_cnt_q != exec_cnt_i. This yields exactly one event per operation, even if exec_cnt stalls at the sample value.
- FSM states: IDLE, DRAIN.
- IDLE + event:
  - Capture SAOUT_i at the end of cycle N.
  - Set beat count and start index:
    - READ: beats=1, start=col_addr9_i[8:7].
    - PARALLEL/RBR: beats=4, start=0.
  - Go to DRAIN; rvalid_o=1 and busy_o=1 from cycle N+1.
- DRAIN:
  - rdata_o = cap[32*idx+31 : 32*idx].
  - rlast_o=1 on the final beat.
  - A beat transfers when rvalid_o && rready_i.
  - On transfer: idx+1 and the next word appears the following cycle, with no bubble.
  - After the last beat: rvalid_o=0, busy_o=0 the next cycle, return to IDLE.
- Handshake:
  - rdata_o and rlast_o are stable while rvalid_o=1 && rready_i=0.
  - rvalid_o never drops without a transfer, except on reset.
- Event during DRAIN:
  - Capture is dropped; overrun_o is set the next cycle.
  - The in-flight drain is unaffected.
  - An event coinciding with the final transfer is also dropped and sets overrun_o.
- overrun_o:
  - Cleared by clr_ovr_i=1.
  - If set and clear occur in the same cycle, set wins.
- pim_en_i deasserting or a mode change mid-DRAIN does not abort the drain.
- Reset mid-DRAIN: immediate return to reset values; the partial capture is discarded.
- LOAD, ERASE, PROGRAM and ZP modes never produce an event.

Optional Feature:
- Macro: EFLASH_READOUT_POPCNT_EN.
- Defined: popcnt_o = count of ones in the 128 captured bits (0..128).
  - Registered with the capture; valid from cycle N+1 and held until the next capture.
  - READ mode counts all 128 bits, not only the returned word.
- Undefined: popcnt_o is tied to 0 and no counter logic is built.

Test Plan:
- READ, col_addr9_i=9'h1A4 (column 105, word 3), SAOUT_i bit 105=1 and all others 0, exec_cnt 9→1, rready_i=1 -> exactly one beat: rdata_o=32'h0000_0200, rlast_o=1; busy_o low 1 cycle after the transfer.
- PARALLEL, SAOUT_i=128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210, sampled at exec_cnt=6 -> beats 32'h7654_3210, 32'hFEDC_BA98, 32'h89AB_CDEF, 32'h0123_4567; rlast_o only on the 4th beat.
- RBR with rready_i held low 5 cycles, then toggled 1/0 -> rdata_o stable while stalled; 4 beats total, in order, none duplicated.
- exec_cnt_i held at 3 for 4 cycles in READ -> a single capture, overrun_o stays 0.
- Second PARALLEL sample event while beat 2 is pending -> overrun_o=1 next cycle; the drain finishes with the original data; clr_ovr_i pulse -> overrun_o=0.
- Reset asserted mid-DRAIN after beat 1 -> rvalid_o=0 and busy_o=0 immediately.
- With EFLASH_READOUT_POPCNT_EN defined -> popcnt_o=64 for the PARALLEL pattern above.
